wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_arb_pkg.sv | 30 +++
 rtl/wb_req_fifo.sv | 61 ++++++
 rtl/wb_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arb_pkg
//  Description : Shared types for the writeback port arbiter. These are the
//                FSM state enum, the register/data widths and the packed
//                side-request FIFO entry.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        STALL  = 2'd1,
        GRANT  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [REG_IDX_W-1:0] sel;
        logic [DATA_W-1:0]    data;
    } req_entry_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_req_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_req_fifo
//  Description : In-order side-request FIFO with registered occupancy count
//                and an always-visible head entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_req_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  req_entry_t                 i_entry,
    input  logic                       i_pop,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output req_entry_t                 o_head
);

    localparam int c_ptr_w = $clog2(DEPTH);

    req_entry_t           r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [$clog2(DEPTH+1)-1:0] r_count;

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (i_pop && !i_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_port_arbiter
//  Description : Shares the register-file write port between the MEM/WB stage
//                and a queued side-update channel. It forces a pipeline stall
//                when the side channel starves. Optional statistics counters
//                are enabled with the WB_ARB_STATS_EN define.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_regWrite,
    input  logic [REG_IDX_W-1:0] wb_writeregsel,
    input  logic [DATA_W-1:0]    wb_data,
    input  logic                 in_req_valid,
    output logic                 in_req_ready,
    input  logic [REG_IDX_W-1:0] in_req_sel,
    input  logic [DATA_W-1:0]    in_req_data,
    output logic                 rf_we,
    output logic [REG_IDX_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic                 stall_req,
`ifdef WB_ARB_STATS_EN
    output logic                 err,
    output logic [15:0]          stat_side_grants,
    output logic [15:0]          stat_forced_stalls
`else
    output logic                 err
`endif
);

    localparam int c_cnt_w    = $clog2(DEPTH + 1);
    localparam int c_starve_w = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cnt_w-1:0]    c_depth       = c_cnt_w'(DEPTH);
    localparam logic [c_starve_w-1:0] c_starve_last = c_starve_w'(STARVE_LIMIT - 1);

    arb_state_e              r_state;
    logic [c_starve_w-1:0]   r_starve;

    logic [c_cnt_w-1:0]      w_count;
    req_entry_t              w_head;
    req_entry_t              w_push_entry;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_fifo_empty;
    logic                    w_grant;
    logic                    w_side_grant;
    logic [REG_IDX_W-1:0]    w_sel;
    logic [DATA_W-1:0]       w_data;
    logic                    w_err_set;
    logic                    w_starve_inc;
    logic                    w_enter_stall;
    logic                    w_wr_en;

    assign w_fifo_empty = (w_count == '0);
    assign in_req_ready = (w_count < c_depth);
    assign w_push       = in_req_valid && in_req_ready;
    assign w_push_entry = '{sel: in_req_sel, data: in_req_data};
    assign stall_req    = (r_state != NORMAL);

    wb_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .o_count (w_count),
        .o_head  (w_head)
    );

    // Grant selection: the pipeline wins except in GRANT, where the head is forced out.
    always_comb begin
        w_pop        = 1'b0;
        w_grant      = 1'b0;
        w_side_grant = 1'b0;
        w_sel        = '0;
        w_data       = '0;
        w_err_set    = 1'b0;
        case (r_state)
            NORMAL, STALL: begin
                if (wb_regWrite) begin
                    w_grant = 1'b1;
                    w_sel   = wb_writeregsel;
                    w_data  = wb_data;
                end else if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_grant      = 1'b1;
                    w_side_grant = 1'b1;
                    w_sel        = w_head.sel;
                    w_data       = w_head.data;
                end
            end
            GRANT: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_grant      = 1'b1;
                    w_side_grant = 1'b1;
                    w_sel        = w_head.sel;
                    w_data       = w_head.data;
                end else begin
                    w_err_set = 1'b1;
                end
                if (wb_regWrite) begin
                    w_err_set = 1'b1;
                end
            end
            default: begin
                w_err_set = 1'b0;
            end
        endcase
    end

    assign w_starve_inc  = (r_state == NORMAL) && !w_fifo_empty && wb_regWrite;
    assign w_enter_stall = w_starve_inc && (r_starve == c_starve_last);
    assign w_wr_en       = w_grant && (w_sel != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= NORMAL;
            r_starve <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            err      <= 1'b0;
        end else begin
            rf_we    <= w_wr_en;
            rf_waddr <= w_wr_en ? w_sel  : '0;
            rf_wdata <= w_wr_en ? w_data : '0;
            if (w_err_set) begin
                err <= 1'b1;
            end
            case (r_state)
                NORMAL: begin
                    if (w_fifo_empty || w_side_grant) begin
                        r_starve <= '0;
                    end else if (w_starve_inc) begin
                        r_starve <= r_starve + 1'b1;
                    end
                    if (w_enter_stall) begin
                        r_state <= STALL;
                    end
                end
                STALL: begin
                    r_state <= GRANT;
                end
                GRANT: begin
                    r_state  <= NORMAL;
                    r_starve <= '0;
                end
                default: begin
                    r_state  <= NORMAL;
                    r_starve <= '0;
                end
            endcase
        end
    end

`ifdef WB_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_side_grants   <= '0;
            stat_forced_stalls <= '0;
        end else begin
            if (w_side_grant) begin
                stat_side_grants <= sat_inc16(stat_side_grants);
            end
            if (w_enter_stall) begin
                stat_forced_stalls <= sat_inc16(stat_forced_stalls);
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_port_arbiter
//  Description : Self-checking bench for wb_port_arbiter against a queue-based
//                reference model of the arbitration rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] data;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        wb_regWrite;
    logic [4:0]  wb_writeregsel;
    logic [31:0] wb_data;
    logic        in_req_valid;
    logic        in_req_ready;
    logic [4:0]  in_req_sel;
    logic [31:0] in_req_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_req;
    logic        err;
`ifdef WB_ARB_STATS_EN
    logic [15:0] stat_side_grants;
    logic [15:0] stat_forced_stalls;
`endif

    int total;
    int bad;

    // Reference model state
    ent_t        m_q[$];
    int          m_phase;     // 0 running, 1 forced stall, 2 forced side grant
    int          m_starve;
    logic        m_err;
    int          m_side_grants;
    int          m_forced;
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;

    wb_port_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .wb_regWrite        (wb_regWrite),
        .wb_writeregsel     (wb_writeregsel),
        .wb_data            (wb_data),
        .in_req_valid       (in_req_valid),
        .in_req_ready       (in_req_ready),
        .in_req_sel         (in_req_sel),
        .in_req_data        (in_req_data),
        .rf_we              (rf_we),
        .rf_waddr           (rf_waddr),
        .rf_wdata           (rf_wdata),
        .stall_req          (stall_req),
`ifdef WB_ARB_STATS_EN
        .err                (err),
        .stat_side_grants   (stat_side_grants),
        .stat_forced_stalls (stat_forced_stalls)
`else
        .err                (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus; the model advances alongside and leaves the
    // values expected on the outputs after the edge.
    task automatic step(input logic ar, input logic aw, input logic [4:0] aws,
                        input logic [31:0] awd, input logic av,
                        input logic [4:0] ais, input logic [31:0] aid);
        int          pre;
        logic        g;
        logic        side;
        logic [4:0]  gs;
        logic [31:0] gd;
        rst            = ar;
        wb_regWrite    = aw;
        wb_writeregsel = aws;
        wb_data        = awd;
        in_req_valid   = av;
        in_req_sel     = ais;
        in_req_data    = aid;
        if (ar) begin
            m_q.delete();
            m_phase = 0; m_starve = 0; m_err = 1'b0;
            m_side_grants = 0; m_forced = 0;
            exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0;
        end else begin
            pre = m_q.size();
            g = 1'b0; side = 1'b0; gs = '0; gd = '0;
            if (m_phase == 2) begin
                if (pre > 0) begin
                    g = 1'b1; side = 1'b1;
                    gs = m_q[0].sel; gd = m_q[0].data;
                end else begin
                    m_err = 1'b1;
                end
                if (aw) m_err = 1'b1;
            end else if (aw) begin
                g = 1'b1; gs = aws; gd = awd;
            end else if (pre > 0) begin
                g = 1'b1; side = 1'b1;
                gs = m_q[0].sel; gd = m_q[0].data;
            end
            if (side) begin
                void'(m_q.pop_front());
                if (m_side_grants < 65535) m_side_grants++;
            end
            if (m_phase == 0) begin
                if (pre == 0 || side) begin
                    m_starve = 0;
                end else if (aw) begin
                    m_starve++;
                    if (m_starve == STARVE_LIMIT) begin
                        m_phase = 1;
                        if (m_forced < 65535) m_forced++;
                    end
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else begin
                m_phase  = 0;
                m_starve = 0;
            end
            if (av && pre < DEPTH) m_q.push_back('{sel: ais, data: aid});
            exp_we    = g && (gs != 5'd0);
            exp_waddr = exp_we ? gs : 5'd0;
            exp_wdata = exp_we ? gd : 32'd0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_reset();
        do_reset();
        do_reset();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
        total++; if (rf_waddr !== 5'd0) begin bad++; $display("FAIL reset_rf_waddr: got %0d want 0", rf_waddr); end
        total++; if (rf_wdata !== 32'd0) begin bad++; $display("FAIL reset_rf_wdata: got %h want 0", rf_wdata); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall_req); end
        total++; if (in_req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", in_req_ready); end
`ifdef WB_ARB_STATS_EN
        total++; if (stat_side_grants !== 16'd0) begin bad++; $display("FAIL reset_stat_side: got %0d want 0", stat_side_grants); end
        total++; if (stat_forced_stalls !== 16'd0) begin bad++; $display("FAIL reset_stat_forced: got %0d want 0", stat_forced_stalls); end
`endif
    endtask

    task automatic test_single_push();
        do_reset();
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hDEAD_BEEF);
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL single_early_we: got %b want 0", rf_we); end
        idle();
        total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL single_we: got %b want 1", rf_we); end
        total++; if (rf_waddr !== 5'd3) begin bad++; $display("FAIL single_waddr: got %0d want 3", rf_waddr); end
        total++; if (rf_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_wdata: got %h want deadbeef", rf_wdata); end
        total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL single_stall: got %b want 0", stall_req); end
        idle();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL single_after_we: got %b want 0", rf_we); end
    endtask

    task automatic test_starve();
        logic want_stall;
        do_reset();
        step(1'b0, 1'b1, 5'd5, 32'h11, 1'b1, 5'd9, 32'hCAFE_0009);
        for (int c = 1; c <= 9; c++) begin
            want_stall = (c == 5 || c == 6);
            total++; if (stall_req !== want_stall) begin bad++; $display("FAIL starve_stall c%0d: got %b want %b", c, stall_req, want_stall); end
            total++;
            if (rf_we !== exp_we || rf_waddr !== exp_waddr || rf_wdata !== exp_wdata) begin
                bad++;
                $display("FAIL starve_rf c%0d: got %b/%0d/%h want %b/%0d/%h", c, rf_we, rf_waddr, rf_wdata, exp_we, exp_waddr, exp_wdata);
            end
            if (c == 7) begin
                total++;
                if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'hCAFE_0009) begin
                    bad++;
                    $display("FAIL starve_side_write: got %b/%0d/%h want 1/9/cafe0009", rf_we, rf_waddr, rf_wdata);
                end
                total++; if (err !== 1'b1) begin bad++; $display("FAIL grant_conflict_err: got %b want 1", err); end
            end
            step(1'b0, 1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0);
        end
        idle();
        idle();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", err); end
`ifdef WB_ARB_STATS_EN
        total++; if (stat_forced_stalls !== 16'd1) begin bad++; $display("FAIL stat_forced: got %0d want 1", stat_forced_stalls); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [36:0] pushed[$];
        logic [36:0] seen[$];
        logic [31:0] d;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            d = $urandom;
            total++; if (in_req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready push%0d: got %b want 1", i, in_req_ready); end
            pushed.push_back({5'(i), d});
            step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i), d);
            if (rf_we) seen.push_back({rf_waddr, rf_wdata});
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            if (rf_we) seen.push_back({rf_waddr, rf_wdata});
        end
        total++; if (seen.size() != 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", seen.size()); end
        for (int i = 0; i < 3 && i < seen.size(); i++) begin
            total++; if (seen[i] !== pushed[i]) begin bad++; $display("FAIL b2b_order %0d: got %h want %h", i, seen[i], pushed[i]); end
        end
        // With the pipeline holding the port, the queue fills up.
        do_reset();
        seen.delete();
        step(1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd10, 32'hA);
        step(1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd11, 32'hB);
        total++; if (in_req_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", in_req_ready); end
        step(1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd12, 32'hC);
        for (int i = 0; i < 4; i++) begin
            idle();
            if (rf_we) seen.push_back({rf_waddr, rf_wdata});
        end
        total++;
        if (seen.size() != 2 || seen[0] !== {5'd10, 32'hA} || seen[1] !== {5'd11, 32'hB}) begin
            bad++;
            $display("FAIL full_drop_order: got %0d writes, want only entries 10 and 11", seen.size());
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        step(1'b0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd20, 32'h20);
        step(1'b0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd21, 32'h21);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0);
        total++; if (stall_req !== 1'b1) begin bad++; $display("FAIL midstall_in_stall: got %b want 1", stall_req); end
        do_reset();
        total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL midstall_stall: got %b want 0", stall_req); end
        total++; if (in_req_ready !== 1'b1) begin bad++; $display("FAIL midstall_ready: got %b want 1", in_req_ready); end
        for (int i = 0; i < 3; i++) begin
            total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL midstall_no_write %0d: got %b want 0", i, rf_we); end
            idle();
        end
    endtask

    task automatic test_reg_zero();
        do_reset();
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234_5678);
        for (int i = 0; i < 2; i++) begin
            total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL zero_we %0d: got %b want 0", i, rf_we); end
            idle();
        end
`ifdef WB_ARB_STATS_EN
        total++; if (stat_side_grants !== 16'd1) begin bad++; $display("FAIL zero_stat_side: got %0d want 1", stat_side_grants); end
`endif
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77);
        idle();
        total++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h77) begin
            bad++;
            $display("FAIL zero_consumed: got %b/%0d/%h want 1/7/77", rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_random();
        logic ar, aw, av;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            total++; if (in_req_ready !== (m_q.size() < DEPTH)) begin bad++; $display("FAIL rand_ready %0d: got %b want %b", i, in_req_ready, (m_q.size() < DEPTH)); end
            total++; if (stall_req !== (m_phase != 0)) begin bad++; $display("FAIL rand_stall %0d: got %b want %b", i, stall_req, (m_phase != 0)); end
            ar = ($urandom_range(0, 199) == 0);
            aw = ($urandom_range(0, 99) < 55);
            av = ($urandom_range(0, 99) < 40);
            step(ar, aw, 5'($urandom_range(0, 31)), $urandom, av, 5'($urandom_range(0, 31)), $urandom);
            total++;
            if (rf_we !== exp_we || rf_waddr !== exp_waddr || rf_wdata !== exp_wdata) begin
                bad++;
                $display("FAIL rand_rf %0d: got %b/%0d/%h want %b/%0d/%h", i, rf_we, rf_waddr, rf_wdata, exp_we, exp_waddr, exp_wdata);
            end
            total++; if (err !== m_err) begin bad++; $display("FAIL rand_err %0d: got %b want %b", i, err, m_err); end
`ifdef WB_ARB_STATS_EN
            total++;
            if (stat_side_grants !== 16'(m_side_grants) || stat_forced_stalls !== 16'(m_forced)) begin
                bad++;
                $display("FAIL rand_stats %0d: got %0d/%0d want %0d/%0d", i, stat_side_grants, stat_forced_stalls, m_side_grants, m_forced);
            end
`endif
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; wb_regWrite = 1'b0; wb_writeregsel = '0; wb_data = '0;
        in_req_valid = 1'b0; in_req_sel = '0; in_req_data = '0;
        m_phase = 0; m_starve = 0; m_err = 1'b0; m_side_grants = 0; m_forced = 0;
        exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0;
        @(negedge clk);
        test_reset();
        test_single_push();
        test_starve();
        test_back_to_back();
        test_reset_mid_stall();
        test_reg_zero();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
